// File: rtl/uart_transmitter_param.sv
// Buffered UART transmitter: FIFO_DEPTH-entry queue feeding an 8N1/8N2-style framer; start bit two cycles after a write into an idle, empty unit.
// A write to a full buffer is dropped and pulses overflow; define UART_TRANSMITTER_PARITY_EN to add a parity bit after the data bits.
module uart_transmitter_param #(
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 32,
  parameter int BASE_DIVISOR = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          write_enable,
  input  logic [DATA_WIDTH-1:0]         data,
  input  logic [$clog2(FIFO_DEPTH):0]   buffer_full_threshold,
  input  logic [1:0]                    baudrate_select,
  input  logic                          two_stop_bits,
  input  logic                          parity_odd,
  output logic                          buffer_full,
  output logic                          buffer_empty,
  output logic                          overflow,
  output logic                          busy,
  output logic                          data_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BASE_DIVISOR * 8 + 1);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

`ifdef UART_TRANSMITTER_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d, thr_eff;
  logic                  full_q, empty_q, ovf_q, line_q, busy_q;
  logic                  line_d, busy_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, head;
  logic [IW-1:0]         bit_q, bit_d;
  logic [BW-1:0]         cnt_q, cnt_d, period;
  logic [1:0]            sel_q, sel_d;
  logic                  two_q, two_d, stop2_q, stop2_d;
  logic                  wr_acc, pop, load, bit_done, nonempty;
`ifdef UART_TRANSMITTER_PARITY_EN
  logic                  par_q, par_d;
`else
  logic                  unused_parity;
  assign unused_parity = parity_odd;
`endif

  // Acceptance depends only on the pre-edge occupancy, so a same-cycle pop never rescues a write.
  assign wr_acc   = write_enable && !reset && (count_q < DEPTH_C);
  assign nonempty = (count_q != '0);
  assign head     = mem[rd_ptr_q];
  assign count_d  = count_q + CW'(wr_acc) - CW'(pop);
  assign thr_eff  = (buffer_full_threshold == '0 || buffer_full_threshold > DEPTH_C)
                    ? DEPTH_C : buffer_full_threshold;
  assign period   = BW'(BASE_DIVISOR) << sel_q;
  assign bit_done = (cnt_q == period - BW'(1));

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    two_d   = two_q;
    stop2_d = stop2_q;
    load    = 1'b0;
    pop     = 1'b0;
`ifdef UART_TRANSMITTER_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: load = nonempty;
      START: begin
        cnt_d = cnt_q + BW'(1);
        if (bit_done) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      DATA: begin
        cnt_d = cnt_q + BW'(1);
        if (bit_done) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + IW'(1);
          if (bit_q == IW'(DATA_WIDTH - 1)) begin
`ifdef UART_TRANSMITTER_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TRANSMITTER_PARITY_EN
      PARITY: begin
        cnt_d = cnt_q + BW'(1);
        if (bit_done) begin
          cnt_d   = '0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        cnt_d = cnt_q + BW'(1);
        if (bit_done) begin
          cnt_d = '0;
          if (two_q && !stop2_q) stop2_d = 1'b1;
          else if (nonempty)     load    = 1'b1;
          else                   state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame settings are captured with the word so mid-frame input changes cannot tear a frame.
    if (load) begin
      pop     = 1'b1;
      state_d = START;
      shift_d = head;
      sel_d   = baudrate_select;
      two_d   = two_stop_bits;
      stop2_d = 1'b0;
      cnt_d   = '0;
`ifdef UART_TRANSMITTER_PARITY_EN
      par_d   = (^head) ^ parity_odd;
`endif
    end

    case (state_d)
      START:   line_d = 1'b0;
      DATA:    line_d = shift_d[0];
`ifdef UART_TRANSMITTER_PARITY_EN
      PARITY:  line_d = par_d;
`endif
      default: line_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (wr_acc) mem[wr_ptr_q] <= data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      line_q   <= 1'b1;
      busy_q   <= 1'b0;
      shift_q  <= '0;
      bit_q    <= '0;
      cnt_q    <= '0;
      sel_q    <= '0;
      two_q    <= 1'b0;
      stop2_q  <= 1'b0;
`ifdef UART_TRANSMITTER_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q  <= count_d;
      full_q   <= (count_d >= thr_eff);
      empty_q  <= (count_d == '0);
      ovf_q    <= write_enable && !wr_acc;
      line_q   <= line_d;
      busy_q   <= busy_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      two_q    <= two_d;
      stop2_q  <= stop2_d;
`ifdef UART_TRANSMITTER_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign buffer_full  = full_q;
  assign buffer_empty = empty_q;
  assign overflow     = ovf_q;
  assign busy         = busy_q;
  assign data_out     = line_q;

endmodule

// File: tb/tb_uart_transmitter_param.sv
// Bench for uart_transmitter_param at default parameters; frames are checked cycle by cycle against a queue of written words.
module tb_uart_transmitter_param;

  localparam int DW = 8;
  localparam int FD = 32;
  localparam int BD = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          write_enable = 1'b0;
  logic [DW-1:0] data = '0;
  logic [5:0]    thr = '0;
  logic [1:0]    sel = '0;
  logic          two_stop = 1'b0;
  logic          parity_odd = 1'b0;
  logic          buffer_full, buffer_empty, overflow, busy, data_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic [1:0]    sel;
    logic          two;
    logic          odd;
  } frame_t;
  frame_t sb[$];

  uart_transmitter_param #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .BASE_DIVISOR(BD)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .write_enable          (write_enable),
    .data                  (data),
    .buffer_full_threshold (thr),
    .baudrate_select       (sel),
    .two_stop_bits         (two_stop),
    .parity_odd            (parity_odd),
    .buffer_full           (buffer_full),
    .buffer_empty          (buffer_empty),
    .overflow              (overflow),
    .busy                  (busy),
    .data_out              (data_out)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic push_write(input logic [DW-1:0] w);
    frame_t f;
    @(posedge clock); #1;
    write_enable = 1'b1;
    data = w;
    f.d = w; f.sel = sel; f.two = two_stop; f.odd = parity_odd;
    sb.push_back(f);
  endtask

  task automatic do_reset();
    @(posedge clock); #1 reset = 1'b1; write_enable = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    sb.delete();
  endtask

  // Caller positions just before the negedge of the first start-bit cycle.
  task automatic rx_frame(input string name);
    frame_t f;
    logic   eb[$];
    int     period, bad;
    logic   gd, gb;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, required a queued word", name);
      return;
    end
    f = sb.pop_front();
    period = BD << f.sel;
    eb.push_back(1'b0);
    for (int i = 0; i < DW; i++) eb.push_back(f.d[i]);
`ifdef UART_TRANSMITTER_PARITY_EN
    eb.push_back((^f.d) ^ f.odd);
`endif
    eb.push_back(1'b1);
    if (f.two) eb.push_back(1'b1);
    checks--;
    for (int b = 0; b < eb.size(); b++) begin
      bad = 0; gd = 1'bx; gb = 1'bx;
      for (int c = 0; c < period; c++) begin
        @(negedge clock);
        if (data_out !== eb[b] || busy !== 1'b1) begin
          if (bad == 0) begin gd = data_out; gb = busy; end
          bad++;
        end
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s bit%0d: got data_out=%b busy=%b, required data_out=%b busy=1 for %0d cycles (%0d wrong)",
                 name, b, gd, gb, eb[b], period, bad);
      end
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (data_out !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: got data_out=%b busy=%b, required 1/0", name, data_out, busy);
    end
  endtask

  task automatic test_reset();
    @(posedge clock); #1 reset = 1'b1; write_enable = 1'b1; data = 8'h5A;
    @(posedge clock); #1;
    @(posedge clock); #1 reset = 1'b0; write_enable = 1'b0;
    @(negedge clock);
    checks++; if (data_out !== 1'b1)     begin errors++; $display("FAIL rst_data_out: got %b required 1", data_out); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++; if (buffer_empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b required 1", buffer_empty); end
    checks++; if (buffer_full !== 1'b0)  begin errors++; $display("FAIL rst_full: got %b required 0", buffer_full); end
    checks++; if (overflow !== 1'b0)     begin errors++; $display("FAIL rst_overflow: got %b required 0", overflow); end
  endtask

  task automatic test_single_frame();
    sel = 2'd0; two_stop = 1'b0; parity_odd = 1'b0; thr = '0;
    push_write(8'hA5);
    @(posedge clock); #1 write_enable = 1'b0;
    @(negedge clock);
    check_idle("a5_cycle_n1");
    rx_frame("a5");
    @(negedge clock);
    check_idle("a5_after");
    checks++;
    if (buffer_empty !== 1'b1) begin errors++; $display("FAIL a5_empty: got %b required 1", buffer_empty); end
  endtask

  task automatic test_parity();
`ifdef UART_TRANSMITTER_PARITY_EN
    sel = 2'd0; two_stop = 1'b0;
    for (int k = 0; k < 2; k++) begin
      parity_odd = k[0];
      push_write(8'h07);
      @(posedge clock); #1 write_enable = 1'b0;
      @(negedge clock);
      rx_frame(k == 0 ? "par_even" : "par_odd");
      @(negedge clock);
      check_idle("par_after");
    end
    parity_odd = 1'b0;
`endif
  endtask

  task automatic test_back_to_back();
    sel = 2'd2; two_stop = 1'b1;
    push_write(8'h3C);
    push_write(8'hC3);
    @(posedge clock); #1 write_enable = 1'b0;
    rx_frame("b2b_first");
    rx_frame("b2b_second");
    @(negedge clock);
    check_idle("b2b_after");
    sel = 2'd0; two_stop = 1'b0;
  endtask

  task automatic test_threshold();
    int cnt;
    thr = 6'd4; sel = 2'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1 write_enable = 1'b1; data = 8'(i + 1);
      @(negedge clock);
      if (i == 4) begin
        checks++;
        if (buffer_full !== 1'b0) begin errors++; $display("FAIL thr_occ3: got buffer_full=%b required 0", buffer_full); end
      end
    end
    @(posedge clock); #1 write_enable = 1'b0;
    @(negedge clock);
    checks++;
    if (buffer_full !== 1'b1) begin errors++; $display("FAIL thr_occ4: got buffer_full=%b required 1", buffer_full); end
    cnt = 0;
    while (buffer_full === 1'b1 && cnt < 400) begin
      @(negedge clock);
      cnt++;
    end
    checks++;
    if (cnt != 157) begin errors++; $display("FAIL thr_drop_time: got %0d cycles required 157", cnt); end
    checks++;
    if (data_out !== 1'b0) begin errors++; $display("FAIL thr_next_start: got data_out=%b required 0", data_out); end
    do_reset();
    thr = '0;
  endtask

  task automatic test_overflow();
    thr = '0; sel = 2'd3;
    @(posedge clock); #1 write_enable = 1'b1; data = 8'hFF;
    @(posedge clock); #1 write_enable = 1'b0;
    repeat (4) @(posedge clock);
    for (int i = 1; i <= 33; i++) begin
      @(posedge clock); #1 write_enable = 1'b1; data = 8'(i);
      @(negedge clock);
      if (i == 32) begin
        checks++;
        if (buffer_full !== 1'b0) begin errors++; $display("FAIL ovf_occ31: got buffer_full=%b required 0", buffer_full); end
      end
      if (i == 33) begin
        checks++;
        if (buffer_full !== 1'b1) begin errors++; $display("FAIL ovf_occ32: got buffer_full=%b required 1", buffer_full); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got overflow=%b required 0", overflow); end
      end
    end
    @(posedge clock); #1 write_enable = 1'b0;
    @(negedge clock);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got overflow=%b required 1", overflow); end
    @(negedge clock);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle: got overflow=%b required 0", overflow); end
    checks++;
    if (buffer_full !== 1'b1) begin errors++; $display("FAIL ovf_full_held: got buffer_full=%b required 1", buffer_full); end
    do_reset();
    sel = 2'd0;
  endtask

  task automatic test_reset_midframe();
    int bad;
    sel = 2'd0; two_stop = 1'b0;
    push_write(8'hA1);
    push_write(8'hB2);
    push_write(8'hC3);
    push_write(8'hD4);
    @(posedge clock); #1 write_enable = 1'b0;
    repeat (40) @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b required 1", busy); end
    @(posedge clock); #1 reset = 1'b1; write_enable = 1'b1; data = 8'hEE;
    @(posedge clock); #1 reset = 1'b0; write_enable = 1'b0;
    sb.delete();
    @(negedge clock);
    check_idle("mid_abort");
    checks++;
    if (buffer_empty !== 1'b1) begin errors++; $display("FAIL mid_empty: got %b required 1", buffer_empty); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow: got %b required 0", overflow); end
    bad = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clock);
      if (data_out !== 1'b1 || busy !== 1'b0 || buffer_empty !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL mid_quiet: got %0d active cycles required 0", bad); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity();
    test_back_to_back();
    test_threshold();
    test_overflow();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
